// File: rtl/fp_ret_pipe_elastic.sv
// Elastic retiming pipeline for FP results: DEPTH register stages carrying
// data/flags/tag with a valid/ready handshake, bubble collapse, flush and occupancy.
module fp_ret_pipe_elastic #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 5,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  occupancy
);

    // Handshake: a transfer happens on any edge where valid and ready are both
    // high; valid and payload stay stable until that edge.

    if (DEPTH < 0 || DEPTH > 8) begin : g_bad_depth
        $error("fp_ret_pipe_elastic: DEPTH must be in 0..8");
    end

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign in_ready  = out_ready & ~flush;
        assign out_valid = in_valid & ~flush;
        assign out_data  = in_data;
        assign out_flags = in_flags;
        assign out_tag   = in_tag;
        assign occupancy = '0;
    end else begin : g_pipe
        localparam int LAST = DEPTH - 1;

        logic [DEPTH-1:0]  v_q, v_d, en;
        logic [DATA_W-1:0] data_q  [DEPTH];
        logic [DATA_W-1:0] data_d  [DEPTH];
        logic [FLAG_W-1:0] flags_q [DEPTH];
        logic [FLAG_W-1:0] flags_d [DEPTH];
        logic [TAG_W-1:0]  tag_q   [DEPTH];
        logic [TAG_W-1:0]  tag_d   [DEPTH];
        logic [CNT_W-1:0]  occ_q, occ_d;
        logic              in_xfer, out_xfer;

        // A stage may load when it is empty or its successor can load, so
        // entries slide into bubbles even while the output is stalled.
        always_comb begin
            en       = '0;
            en[LAST] = out_ready | ~v_q[LAST];
            for (int i = LAST - 1; i >= 0; i--) begin
                en[i] = ~v_q[i] | en[i+1];
            end
        end

        assign in_ready = en[0] & ~flush;
        assign in_xfer  = in_valid & in_ready;
        assign out_xfer = v_q[LAST] & out_ready;

        always_comb begin
            v_d     = v_q;
            data_d  = data_q;
            flags_d = flags_q;
            tag_d   = tag_q;
            if (en[0]) begin
                v_d[0]     = in_xfer;
                data_d[0]  = in_data;
                flags_d[0] = in_flags;
                tag_d[0]   = in_tag;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (en[i]) begin
                    v_d[i]     = v_q[i-1];
                    data_d[i]  = data_q[i-1];
                    flags_d[i] = flags_q[i-1];
                    tag_d[i]   = tag_q[i-1];
                end
            end
            if (flush) begin
                v_d = '0;
            end
        end

        always_comb begin
            occ_d = occ_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
            if (flush) begin
                occ_d = '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= '0;
                occ_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i]  <= '0;
                    flags_q[i] <= '0;
                    tag_q[i]   <= '0;
                end
            end else begin
                v_q   <= v_d;
                occ_q <= occ_d;
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i]  <= data_d[i];
                    flags_q[i] <= flags_d[i];
                    tag_q[i]   <= tag_d[i];
                end
            end
        end

        assign out_valid = v_q[LAST];
        assign out_data  = data_q[LAST];
        assign out_flags = flags_q[LAST];
        assign out_tag   = tag_q[LAST];
        assign occupancy = occ_q;
    end

endmodule

// File: doc/fp_ret_pipe_elastic.md
Name: fp_ret_pipe_elastic

Overview:
- Parametrised elastic retiming pipeline placed on the result path of the FP units (div/sqrt, add, mul) to give synthesis registers to retime across.
- Generalises the fixed output delay line: configurable data width and depth, a per-stage valid bit, a valid/ready handshake with backpressure, bubble collapse, flush, and an occupancy count.
- Sits between an FP core's result/flags and the downstream consumer.
- Carries an opaque tag alongside the data so that ops can be matched on retirement.

Parameters:
- DATA_W, 32, width of the result payload.
- FLAG_W, 5, width of the exception flags (NV, DZ, OF, UF, NX).
- TAG_W, 4, width of the opaque op tag; must be at least 1.
- DEPTH, 2, number of register stages, range 0..8. 0 selects combinational passthrough.
- CNT_W, $clog2(DEPTH+1) (1 when DEPTH=0), width of the occupancy count.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discards all in-flight entries.
- in_valid  in  1  upstream holds a result.
- in_ready  out  1  pipe accepts the result this cycle.
- in_data  in  DATA_W  result payload.
- in_flags  in  FLAG_W  exception flags.
- in_tag  in  TAG_W  op tag.
- out_valid  out  1  stage DEPTH-1 holds a valid entry.
- out_ready  in  1  downstream accepts the entry.
- out_data  out  DATA_W  payload of stage DEPTH-1.
- out_flags  out  FLAG_W  flags of stage DEPTH-1.
- out_tag  out  TAG_W  tag of stage DEPTH-1.
- occupancy  out  CNT_W  number of valid stages.

Behaviour:
- Structure: stages 0..DEPTH-1. Each stage holds v[i] plus data, flags and tag.
  - Stage 0 is fed from the in_* ports.
  - Stage i is fed from stage i-1.
- Stage load enable:
  - en[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - en[i] = ~v[i] | en[i+1].
  - This is a combinational ready chain; no registered ready.
- in_ready = en[0] & ~flush.
- On each edge, for every stage with en[i]=1:
  - v[i] <= source valid, where the source valid of stage 0 is in_valid & in_ready.
  - The payload is copied from the source.
  - A stage with en[i]=0 holds its contents.
- Bubble collapse: a stalled output does not block upstream stages that sit behind empty stages. Entries advance into any empty downstream slot.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Entries leave in strict FIFO order; no entry is reordered, duplicated or dropped.
- Latency with no stall: an entry accepted at edge N has out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles after it is presented. Throughput is 1 per cycle.
- Backpressure: while out_ready=0 and all stages are valid, in_ready=0. When out_ready rises, in_ready=1 in that same cycle.
- Input is don't-care when in_valid=0. The payload still loads into a stage whose v is cleared.
- Flush:
  - At the next edge all v[i] <= 0 and occupancy becomes 0.
  - flush overrides a simultaneous input or output transfer: in_ready=0, and the input entry is not captured.
  - out_valid still reflects the current cycle, so a downstream handshake in the flush cycle is legal and counts as delivered.
- occupancy: registered count of valid stages.
  - Next value = current + input transfer - output transfer, or 0 on flush.
  - It never exceeds DEPTH and never wraps.
- Reset (asynchronous assert, synchronous-release usage):
  - All v[i], payloads and occupancy go to 0.
  - While rst=1: out_valid=0, out_data=0, out_flags=0, out_tag=0, occupancy=0.
  - in_ready=1 when DEPTH>0.
  - A reset asserted mid-stream drops all entries.
- DEPTH=0:
  - out_* = in_*, in_ready = out_ready & ~flush, out_valid = in_valid & ~flush.
  - occupancy = 0. No state.
- An assertion fires if DEPTH is outside 0..8.

Test Plan:
- Reset/idle, DEPTH=2:
  - Stimulus: assert rst mid-cycle with entries in flight.
  - Required: out_valid, out_data and occupancy are 0 immediately; in_ready=1 after release.
- Streaming, DEPTH=3:
  - Stimulus: present in_data 0x3F800000, 0x40000000, 0x40400000 with tags 1, 2, 3 on consecutive cycles; out_ready=1.
  - Required: each appears 3 cycles after being presented, in order; occupancy peaks at 3.
- Backpressure, DEPTH=3:
  - Stimulus: hold out_ready=0 while feeding 5 entries.
  - Required: in_ready=0 after 3 accepts and occupancy=3. Then set out_ready=1: all 5 entries arrive in order, with no loss and no duplicate.
- Bubble collapse, DEPTH=4:
  - Stimulus: one entry, then 2 idle cycles, then out_ready=0 and another entry.
  - Required: the second entry advances into stage 2, directly behind the stalled first entry; occupancy=2.
- Flush, DEPTH=3:
  - Stimulus: 3 entries in flight with in_valid=1 and tag 7 presented in the flush cycle.
  - Required: in_ready=0 that cycle; the next cycle has out_valid=0 and occupancy=0; tag 7 never appears at the output.
- Passthrough, DEPTH=0:
  - Stimulus: in 0x7FC00000 with flags 0x10.
  - Required: out_data and out_flags follow combinationally in the same cycle; in_ready equals out_ready.
